pe_conv1d_param: RTL and testbench
==================================

Name: pe_conv1d_param

Overview:
- Parametrised successor of the row-stationary PE. Computes one 1-D convolution row: each output is a dot product over a kernel_w-column by ch_size-channel window, plus an optional accumulated input psum. Output is PSUM_W-bit signed, saturating.
- Kernel width, channel count and data/psum widths are generalised. Adds:
  - runtime-selectable ipsum accumulation;
  - a full-precision signed multiplier;
  - a row_done pulse.
- Sits in the PE array. Fed by GLB scatter buses, drains to the psum gather bus.

Parameters:
- KW_MAX, 3, maximum kernel width in columns (1..8).
- CH_MAX, 4, maximum channels; also number of lanes in one ifmap beat.
- DATA_W, 8, signed ifmap/filter element width.
- PSUM_W, 24, signed psum width; PSUM_W >= 2*DATA_W+4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- set_info  in  1  config strobe; accepted only in IDLE
- ch_size  in  clog2(CH_MAX+1)  channels used, 1..CH_MAX
- kernel_w  in  clog2(KW_MAX+1)  kernel columns, 1..KW_MAX
- ofmap_col  in  6  outputs per row, 1..63
- acc_en  in  1  1: add ipsum before output
- filter_valid  in  1  filter beat valid
- filter  in  DATA_W  one filter element
- filter_ready  out  1  filter beat accepted when valid&ready
- ifmap_valid  in  1  ifmap beat valid
- ifmap  in  CH_MAX*DATA_W  one column; channel c at [c*DATA_W +: DATA_W]
- ifmap_ready  out  1
- ipsum_valid  in  1
- ipsum  in  PSUM_W
- ipsum_ready  out  1
- opsum_ready  in  1
- opsum  out  PSUM_W  current psum register
- opsum_valid  out  1
- row_done  out  1  one-cycle pulse after last output of a row

Behaviour:
- Reset: state IDLE; spads, psum, counters and config registers cleared. All outputs 0. Reset mid-operation aborts immediately; set_info is required again.
- States: IDLE, LOAD, MAC, ACC, OUT.
- IDLE -> LOAD on set_info. Config is latched that cycle. set_info outside IDLE is ignored.
- LOAD, filter:
  - filter_ready=1 until kernel_w*ch_size elements are stored; this happens only for the first output of a row.
  - Fill order: channel fastest, then column; f[col][ch].
- LOAD, ifmap:
  - ifmap_ready=1 until the window is full. The first output of a row needs kernel_w beats; each later output needs 1 beat, loaded into column kernel_w-1.
  - Lanes >= ch_size are ignored.
- Filter and ifmap handshakes may occur in the same cycle.
- LOAD -> MAC the cycle after both loads are complete.
- MAC:
  - One product per cycle; kernel_w*ch_size cycles. Same channel-fastest order.
  - product = signed(DATA_W) x signed(DATA_W), full 2*DATA_W precision, sign-extended to PSUM_W.
  - psum <= sat(psum + product).
  - On the last product: -> ACC if acc_en, else -> OUT.
- ACC: ipsum_ready=1. On handshake, psum <= sat(psum + ipsum), -> OUT.
- Saturation: if both operands have the same sign and the sum's sign differs, clamp to +2^(PSUM_W-1)-1 or -2^(PSUM_W-1) by operand sign.
- OUT:
  - opsum_valid=1; opsum is stable until handshake.
  - On handshake, out_cnt increments.
  - Row not done (out_cnt != ofmap_col-1): shift window left one column, clear column kernel_w-1 and psum, keep filters, -> LOAD.
  - Row done: clear all spads, psum and out_cnt; pulse row_done next cycle; -> LOAD for the next row with full reload.
- Latency, first output: (kernel_w + 1 cycles min load) then kernel_w*ch_size MAC cycles, then OUT. With KW=3, C=1 and back-to-back inputs, opsum_valid rises at cycle 7 after set_info.
- kernel_w=1: no shift data is retained; each output loads one column.
- Backpressure: any ready/valid may be held low indefinitely. No state advances without a handshake.

Test Plan:
- set_info (C=1, K=3, ofmap_col=3, acc_en=0); filters 1,2,3; ifmap columns 1,2,3,4,5 -> opsum 14, 20, 26, then a row_done pulse; exactly 5 ifmap and 3 filter handshakes.
- C=2, K=2, acc_en=1, filters f[0]={1,-1}, f[1]={2,-2}; columns {3,1},{4,2}; ipsum=100 -> opsum 100+(3-1)+(8-4) = 106.
- Saturation: acc_en=1, products sum 100, ipsum=0x7FFFF0 -> opsum 0x7FFFFF. Filter -128 with ifmap 127 repeated to overflow negative -> 0x800000.
- Backpressure: opsum_ready=0 for 5 cycles with opsum_valid=1 -> opsum unchanged, ifmap_ready stays 0, no shift.
- Assert rst mid-MAC -> all outputs 0 next edge. set_info ignored while in OUT; a subsequent IDLE set_info restarts cleanly with the first-case results.
- ch_size=3, CH_MAX=4: lane 3 driven 0x7F -> result unaffected.

Source files
------------

// File: rtl/pe_conv1d_param_if.sv
// Bus bundle between the GLB scatter/gather fabric and one pe_conv1d_param.
interface pe_conv1d_param_if #(
    parameter int unsigned KW_MAX = 3,
    parameter int unsigned CH_MAX = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PSUM_W = 24
);
    localparam int unsigned CHW = $clog2(CH_MAX + 1);
    localparam int unsigned KWW = $clog2(KW_MAX + 1);
    localparam int unsigned IFW = CH_MAX * DATA_W;

    logic              set_info;
    logic [CHW-1:0]    ch_size;
    logic [KWW-1:0]    kernel_w;
    logic [5:0]        ofmap_col;
    logic              acc_en;
    logic              filter_valid;
    logic [DATA_W-1:0] filter;
    logic              filter_ready;
    logic              ifmap_valid;
    logic [IFW-1:0]    ifmap;
    logic              ifmap_ready;
    logic              ipsum_valid;
    logic [PSUM_W-1:0] ipsum;
    logic              ipsum_ready;
    logic              opsum_ready;
    logic [PSUM_W-1:0] opsum;
    logic              opsum_valid;
    logic              row_done;

    modport master (
        output set_info, ch_size, kernel_w, ofmap_col, acc_en,
        output filter_valid, filter, ifmap_valid, ifmap,
        output ipsum_valid, ipsum, opsum_ready,
        input  filter_ready, ifmap_ready, ipsum_ready,
        input  opsum, opsum_valid, row_done
    );

    modport slave (
        input  set_info, ch_size, kernel_w, ofmap_col, acc_en,
        input  filter_valid, filter, ifmap_valid, ifmap,
        input  ipsum_valid, ipsum, opsum_ready,
        output filter_ready, ifmap_ready, ipsum_ready,
        output opsum, opsum_valid, row_done
    );
endinterface

// File: rtl/pe_conv1d_param.sv
// Row-stationary 1-D convolution PE: kernel_w x ch_size dot product per output,
// optional ipsum accumulation, saturating PSUM_W-bit signed result.
module pe_conv1d_param #(
    parameter int unsigned KW_MAX = 3,
    parameter int unsigned CH_MAX = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PSUM_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    pe_conv1d_param_if.slave  bus
);
    localparam int unsigned CHW  = $clog2(CH_MAX + 1);
    localparam int unsigned KWW  = $clog2(KW_MAX + 1);
    localparam int unsigned OCW  = 6;
    localparam int unsigned COLW = CH_MAX * DATA_W;
    localparam int unsigned SPW  = KW_MAX * COLW;
    localparam int unsigned PRW  = 2 * DATA_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_MAC  = 3'd2;
    localparam logic [2:0] S_ACC  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CHW-1:0]    ch_size_q, ch_size_d;
    logic [KWW-1:0]    kernel_w_q, kernel_w_d;
    logic [OCW-1:0]    ofmap_col_q, ofmap_col_d;
    logic              acc_en_q, acc_en_d;
    logic [SPW-1:0]    f_q, f_d;
    logic [SPW-1:0]    w_q, w_d;
    logic [KWW-1:0]    fcol_q, fcol_d;
    logic [CHW-1:0]    fch_q, fch_d;
    logic              f_done_q, f_done_d;
    logic [KWW-1:0]    wcol_q, wcol_d;
    logic              i_done_q, i_done_d;
    logic [KWW-1:0]    mcol_q, mcol_d;
    logic [CHW-1:0]    mch_q, mch_d;
    logic [OCW-1:0]    out_cnt_q, out_cnt_d;
    logic [PSUM_W-1:0] psum_q, psum_d;
    logic              filter_ready_q, filter_ready_d;
    logic              ifmap_ready_q, ifmap_ready_d;
    logic              ipsum_ready_q, ipsum_ready_d;
    logic              opsum_valid_q, opsum_valid_d;
    logic              row_done_q, row_done_d;

    logic [CHW-1:0]           ch_last;
    logic [KWW-1:0]           kw_last;
    int unsigned              f_off, w_off, m_off;
    logic signed [DATA_W-1:0] mac_f, mac_w;
    logic signed [PRW-1:0]    mac_prod;
    logic [PSUM_W-1:0]        mac_ext;

    // Signed add that clamps to the PSUM_W range instead of wrapping.
    function automatic logic [PSUM_W-1:0] sat_add(input logic [PSUM_W-1:0] a,
                                                   input logic [PSUM_W-1:0] b);
        logic [PSUM_W-1:0] s;
        s = a + b;
        if ((a[PSUM_W-1] == b[PSUM_W-1]) && (s[PSUM_W-1] != a[PSUM_W-1]))
            s = a[PSUM_W-1] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
        return s;
    endfunction

    // Spad addressing and the full-precision product for the current MAC step.
    always_comb begin
        ch_last  = ch_size_q - CHW'(1);
        kw_last  = kernel_w_q - KWW'(1);
        f_off    = (32'(fcol_q) * CH_MAX + 32'(fch_q)) * DATA_W;
        w_off    = 32'(wcol_q) * COLW;
        m_off    = (32'(mcol_q) * CH_MAX + 32'(mch_q)) * DATA_W;
        mac_f    = f_q[m_off +: DATA_W];
        mac_w    = w_q[m_off +: DATA_W];
        mac_prod = PRW'(mac_f) * PRW'(mac_w);
        mac_ext  = {{(PSUM_W-PRW){mac_prod[PRW-1]}}, mac_prod};
    end

    // Next-state, spad update and registered-output decode.
    always_comb begin
        state_d     = state_q;
        ch_size_d   = ch_size_q;
        kernel_w_d  = kernel_w_q;
        ofmap_col_d = ofmap_col_q;
        acc_en_d    = acc_en_q;
        f_d         = f_q;
        w_d         = w_q;
        fcol_d      = fcol_q;
        fch_d       = fch_q;
        f_done_d    = f_done_q;
        wcol_d      = wcol_q;
        i_done_d    = i_done_q;
        mcol_d      = mcol_q;
        mch_d       = mch_q;
        out_cnt_d   = out_cnt_q;
        psum_d      = psum_q;
        row_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.set_info) begin
                    ch_size_d   = bus.ch_size;
                    kernel_w_d  = bus.kernel_w;
                    ofmap_col_d = bus.ofmap_col;
                    acc_en_d    = bus.acc_en;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.filter_valid && filter_ready_q) begin
                    f_d[f_off +: DATA_W] = bus.filter;
                    if (fch_q == ch_last) begin
                        fch_d = '0;
                        if (fcol_q == kw_last) begin
                            fcol_d   = '0;
                            f_done_d = 1'b1;
                        end else begin
                            fcol_d = fcol_q + KWW'(1);
                        end
                    end else begin
                        fch_d = fch_q + CHW'(1);
                    end
                end
                if (bus.ifmap_valid && ifmap_ready_q) begin
                    for (int c = 0; c < int'(CH_MAX); c++) begin
                        if (32'(c) < 32'(ch_size_q))
                            w_d[w_off + 32'(c) * DATA_W +: DATA_W] = bus.ifmap[c*DATA_W +: DATA_W];
                    end
                    if (wcol_q == kw_last)
                        i_done_d = 1'b1;
                    else
                        wcol_d = wcol_q + KWW'(1);
                end
                if (f_done_q && i_done_q)
                    state_d = S_MAC;
            end
            S_MAC: begin
                psum_d = sat_add(psum_q, mac_ext);
                if (mch_q == ch_last) begin
                    mch_d = '0;
                    if (mcol_q == kw_last) begin
                        mcol_d  = '0;
                        state_d = acc_en_q ? S_ACC : S_OUT;
                    end else begin
                        mcol_d = mcol_q + KWW'(1);
                    end
                end else begin
                    mch_d = mch_q + CHW'(1);
                end
            end
            S_ACC: begin
                if (bus.ipsum_valid && ipsum_ready_q) begin
                    psum_d  = sat_add(psum_q, bus.ipsum);
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.opsum_ready && opsum_valid_q) begin
                    psum_d   = '0;
                    i_done_d = 1'b0;
                    state_d  = S_LOAD;
                    if (out_cnt_q == ofmap_col_q - OCW'(1)) begin
                        // End of row: full reload of filters and window.
                        out_cnt_d  = '0;
                        f_d        = '0;
                        w_d        = '0;
                        fcol_d     = '0;
                        fch_d      = '0;
                        f_done_d   = 1'b0;
                        wcol_d     = '0;
                        row_done_d = 1'b1;
                    end else begin
                        // Slide window by one column; only the newest column reloads.
                        out_cnt_d = out_cnt_q + OCW'(1);
                        w_d       = w_q >> COLW;
                        w_d[32'(kw_last) * COLW +: COLW] = '0;
                        wcol_d    = kw_last;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        filter_ready_d = (state_d == S_LOAD) && !f_done_d;
        ifmap_ready_d  = (state_d == S_LOAD) && !i_done_d;
        ipsum_ready_d  = (state_d == S_ACC);
        opsum_valid_d  = (state_d == S_OUT);
    end

    // State and datapath registers with asynchronous abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ch_size_q      <= '0;
            kernel_w_q     <= '0;
            ofmap_col_q    <= '0;
            acc_en_q       <= 1'b0;
            f_q            <= '0;
            w_q            <= '0;
            fcol_q         <= '0;
            fch_q          <= '0;
            f_done_q       <= 1'b0;
            wcol_q         <= '0;
            i_done_q       <= 1'b0;
            mcol_q         <= '0;
            mch_q          <= '0;
            out_cnt_q      <= '0;
            psum_q         <= '0;
            filter_ready_q <= 1'b0;
            ifmap_ready_q  <= 1'b0;
            ipsum_ready_q  <= 1'b0;
            opsum_valid_q  <= 1'b0;
            row_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_size_q      <= ch_size_d;
            kernel_w_q     <= kernel_w_d;
            ofmap_col_q    <= ofmap_col_d;
            acc_en_q       <= acc_en_d;
            f_q            <= f_d;
            w_q            <= w_d;
            fcol_q         <= fcol_d;
            fch_q          <= fch_d;
            f_done_q       <= f_done_d;
            wcol_q         <= wcol_d;
            i_done_q       <= i_done_d;
            mcol_q         <= mcol_d;
            mch_q          <= mch_d;
            out_cnt_q      <= out_cnt_d;
            psum_q         <= psum_d;
            filter_ready_q <= filter_ready_d;
            ifmap_ready_q  <= ifmap_ready_d;
            ipsum_ready_q  <= ipsum_ready_d;
            opsum_valid_q  <= opsum_valid_d;
            row_done_q     <= row_done_d;
        end
    end

    assign bus.filter_ready = filter_ready_q;
    assign bus.ifmap_ready  = ifmap_ready_q;
    assign bus.ipsum_ready  = ipsum_ready_q;
    assign bus.opsum        = psum_q;
    assign bus.opsum_valid  = opsum_valid_q;
    assign bus.row_done     = row_done_q;
endmodule

// File: tb/tb_pe_conv1d_param.sv
// Scoreboard bench for pe_conv1d_param: directed rows with hand-computed psums.
`timescale 1ns/1ps
module tb_pe_conv1d_param;
    localparam int unsigned KW_MAX = 3;
    localparam int unsigned CH_MAX = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PSUM_W = 24;
    localparam int unsigned CHW    = $clog2(CH_MAX + 1);
    localparam int unsigned KWW    = $clog2(KW_MAX + 1);
    localparam int unsigned IFW    = CH_MAX * DATA_W;

    logic clk;
    logic rst;

    pe_conv1d_param_if #(.KW_MAX(KW_MAX), .CH_MAX(CH_MAX), .DATA_W(DATA_W), .PSUM_W(PSUM_W)) bus ();

    pe_conv1d_param #(.KW_MAX(KW_MAX), .CH_MAX(CH_MAX), .DATA_W(DATA_W), .PSUM_W(PSUM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int f_hs, i_hs, p_hs, rd_cnt;
    logic [PSUM_W-1:0] exp_q[$];
    logic [DATA_W-1:0] fq[$];
    logic [IFW-1:0]    iq[$];
    logic [PSUM_W-1:0] pq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic [IFW-1:0] col4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Handshake and row_done counters, sampled mid-cycle.
    initial begin : counters
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.filter_valid && bus.filter_ready) f_hs++;
                if (bus.ifmap_valid && bus.ifmap_ready)   i_hs++;
                if (bus.ipsum_valid && bus.ipsum_ready)   p_hs++;
                if (bus.row_done)                         rd_cnt++;
            end
        end
    end

    // Scoreboard monitor: pops an expected psum on every opsum handshake.
    initial begin : monitor
        logic [PSUM_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.opsum_valid && bus.opsum_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL opsum_unexpected: got 0x%0h expected none", bus.opsum);
                end else begin
                    e = exp_q.pop_front();
                    check("opsum", 32'(bus.opsum), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.set_info = 1'b0; bus.ch_size = '0; bus.kernel_w = '0; bus.ofmap_col = '0; bus.acc_en = 1'b0;
        bus.filter_valid = 1'b0; bus.filter = '0; bus.ifmap_valid = 1'b0; bus.ifmap = '0;
        bus.ipsum_valid = 1'b0; bus.ipsum = '0; bus.opsum_ready = 1'b0;
        exp_q.delete(); fq.delete(); iq.delete(); pq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_row(input int ch, input int kw, input int oc, input int acc);
        @(posedge clk); #1;
        bus.ch_size = CHW'(ch); bus.kernel_w = KWW'(kw); bus.ofmap_col = 6'(oc); bus.acc_en = acc[0];
        bus.set_info = 1'b1;
        @(posedge clk); #1;
        bus.set_info = 1'b0;
    endtask

    task automatic feed_filter();
        int t;
        while (fq.size() > 0) begin
            bus.filter = fq[0]; bus.filter_valid = 1'b1; t = 0;
            do begin @(negedge clk); t++; end while (!bus.filter_ready && t < 500);
            if (!bus.filter_ready) begin fail_now("filter_wait"); bus.filter_valid = 1'b0; fq.delete(); return; end
            @(posedge clk); #1;
            void'(fq.pop_front());
        end
        bus.filter_valid = 1'b0;
    endtask

    task automatic feed_ifmap();
        int t;
        while (iq.size() > 0) begin
            bus.ifmap = iq[0]; bus.ifmap_valid = 1'b1; t = 0;
            do begin @(negedge clk); t++; end while (!bus.ifmap_ready && t < 500);
            if (!bus.ifmap_ready) begin fail_now("ifmap_wait"); bus.ifmap_valid = 1'b0; iq.delete(); return; end
            @(posedge clk); #1;
            void'(iq.pop_front());
        end
        bus.ifmap_valid = 1'b0;
    endtask

    task automatic feed_ipsum();
        int t;
        while (pq.size() > 0) begin
            bus.ipsum = pq[0]; bus.ipsum_valid = 1'b1; t = 0;
            do begin @(negedge clk); t++; end while (!bus.ipsum_ready && t < 500);
            if (!bus.ipsum_ready) begin fail_now("ipsum_wait"); bus.ipsum_valid = 1'b0; pq.delete(); return; end
            @(posedge clk); #1;
            void'(pq.pop_front());
        end
        bus.ipsum_valid = 1'b0;
    endtask

    // Accepts n outputs; optionally stalls the first one and pokes set_info meanwhile.
    task automatic drain(input int n, input int lat, input int stall, input logic [PSUM_W-1:0] stall_val);
        int cyc;
        bit ok;
        for (int k = 0; k < n; k++) begin
            cyc = 0; ok = 1'b0;
            while (cyc < 300) begin
                @(negedge clk);
                if (bus.opsum_valid) begin ok = 1'b1; break; end
                cyc++;
            end
            if (!ok) begin fail_now("opsum_wait"); return; end
            if (k == 0 && lat >= 0) check("first_latency", cyc, lat);
            if (k == 0 && stall != 0) begin
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    if (s == 1) begin
                        bus.ch_size = CHW'(1); bus.kernel_w = KWW'(1); bus.ofmap_col = 6'd1;
                        bus.set_info = 1'b1;
                    end else begin
                        bus.set_info = 1'b0;
                    end
                    @(negedge clk);
                    check("stall_opsum", 32'(bus.opsum), 32'(stall_val));
                    check("stall_valid", 32'(bus.opsum_valid), 32'd1);
                    check("stall_ifmap_ready", 32'(bus.ifmap_ready), 32'd0);
                end
            end
            @(posedge clk); #1;
            bus.set_info = 1'b0;
            bus.opsum_ready = 1'b1;
            @(posedge clk); #1;
            bus.opsum_ready = 1'b0;
        end
    endtask

    task automatic run_case(input string name, input int ch, input int kw, input int oc, input int acc,
                            input int lat, input int stall, input logic [PSUM_W-1:0] stall_val);
        int nf, ni, np, f0, i0, p0, r0;
        nf = fq.size(); ni = iq.size(); np = pq.size();
        f0 = f_hs; i0 = i_hs; p0 = p_hs; r0 = rd_cnt;
        start_row(ch, kw, oc, acc);
        fork
            feed_filter();
            feed_ifmap();
            feed_ipsum();
            drain(oc, lat, stall, stall_val);
        join
        repeat (3) @(negedge clk);
        check({name, "_filter_hs"}, f_hs - f0, nf);
        check({name, "_ifmap_hs"}, i_hs - i0, ni);
        check({name, "_ipsum_hs"}, p_hs - p0, np);
        check({name, "_row_done"}, rd_cnt - r0, 1);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        do_reset();
        @(negedge clk);
        check("rst_filter_ready", 32'(bus.filter_ready), 32'd0);
        check("rst_ifmap_ready", 32'(bus.ifmap_ready), 32'd0);
        check("rst_ipsum_ready", 32'(bus.ipsum_ready), 32'd0);
        check("rst_opsum", 32'(bus.opsum), 32'd0);
        check("rst_opsum_valid", 32'(bus.opsum_valid), 32'd0);
        check("rst_row_done", 32'(bus.row_done), 32'd0);

        // K=3 C=1 row with backpressure on the first output and set_info in OUT.
        fq = '{8'd1, 8'd2, 8'd3};
        iq = '{col4(1,0,0,0), col4(2,0,0,0), col4(3,0,0,0), col4(4,0,0,0), col4(5,0,0,0)};
        exp_q = '{24'd14, 24'd20, 24'd26};
        run_case("rowA", 1, 3, 3, 0, 7, 1, 24'd14);

        // Abort in the middle of MAC.
        do_reset();
        fq = '{8'd1, 8'd2, 8'd3};
        iq = '{col4(1,0,0,0), col4(2,0,0,0), col4(3,0,0,0)};
        start_row(1, 3, 3, 0);
        fork
            feed_filter();
            feed_ifmap();
        join
        @(posedge clk);
        @(posedge clk); #1;
        check("midmac_psum", 32'(bus.opsum), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_opsum", 32'(bus.opsum), 32'd0);
        check("abort_opsum_valid", 32'(bus.opsum_valid), 32'd0);
        check("abort_filter_ready", 32'(bus.filter_ready), 32'd0);
        check("abort_ifmap_ready", 32'(bus.ifmap_ready), 32'd0);
        check("abort_ipsum_ready", 32'(bus.ipsum_ready), 32'd0);
        check("abort_row_done", 32'(bus.row_done), 32'd0);

        // Clean restart from IDLE reproduces the first row.
        do_reset();
        fq = '{8'd1, 8'd2, 8'd3};
        iq = '{col4(1,0,0,0), col4(2,0,0,0), col4(3,0,0,0), col4(4,0,0,0), col4(5,0,0,0)};
        exp_q = '{24'd14, 24'd20, 24'd26};
        run_case("rowC", 1, 3, 3, 0, 7, 0, 24'd0);

        // C=2 K=2 with ipsum accumulation: 100 + (3-1) + (8-4).
        do_reset();
        fq = '{8'd1, 8'hFF, 8'd2, 8'hFE};
        iq = '{col4(3,1,0,0), col4(4,2,0,0)};
        pq = '{24'd100};
        exp_q = '{24'd106};
        run_case("acc", 2, 2, 1, 1, -1, 0, 24'd0);

        // K=1 keeps no window data between outputs: 2*1+3*1, 2*2+3*(-1).
        do_reset();
        fq = '{8'd2, 8'd3};
        iq = '{col4(1,1,0,0), col4(2,-1,0,0)};
        exp_q = '{24'd5, 24'd1};
        run_case("k1", 2, 1, 2, 0, -1, 0, 24'd0);

        // Positive saturation: 100 + 0x7FFFF0.
        do_reset();
        fq = '{8'd10};
        iq = '{col4(10,0,0,0)};
        pq = '{24'h7FFFF0};
        exp_q = '{24'h7FFFFF};
        run_case("satpos", 1, 1, 1, 1, -1, 0, 24'd0);

        // Negative saturation: 12 x (-128*127) plus a large negative ipsum.
        do_reset();
        for (int i = 0; i < 12; i++) fq.push_back(8'h80);
        iq = '{col4(127,127,127,127), col4(127,127,127,127), col4(127,127,127,127)};
        pq = '{24'h800100};
        exp_q = '{24'h800000};
        run_case("satneg", 4, 3, 1, 1, -1, 0, 24'd0);

        // ch_size=3: lane 3 carries 0x7F and must not contribute.
        do_reset();
        fq = '{8'd1, 8'd2, 8'd3};
        iq = '{col4(1,1,1,127)};
        exp_q = '{24'd6};
        run_case("ch3", 3, 1, 1, 0, -1, 0, 24'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
